gray4_monitor: RTL
==================

# gray4_monitor

Downstream checker for the 4-bit Gray counter stage. It samples the counter's Gray output every clock and decodes it to binary. It verifies that every change is a legal single step (+1 mod 16) and that the counter's `tc` and `ceo` flags agree with the code value. It also counts completed wraps and reports faults, for display and lab self-checks.

## Interface
Parameters:
- `W`, 4, Gray/binary width; the block is specified and tested at 4.
- `NCYC`, 8, width of the wrap counter.
- `NERR`, 4, width of the saturating error counter.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `r`  in  1  reset, synchronous, active-low (0 = reset on the next rising `clk`).
- `ce`  in  1  the same clock-enable that drives the counter.
- `gi`  in  W  Gray code from the counter's `Y`.
- `tc`  in  1  counter terminal-count flag.
- `ceo`  in  1  counter cascade-enable output.
- `B`  out  W  registered binary of `gi`.
- `step`  out  1  one-clock pulse per legal +1 advance, including 15→0.
- `rsy`  out  1  one-clock pulse on resync (jump to 0 from any value other than 15).
- `err`  out  1  sticky fault flag; high exactly while `st`=FAULT.
- `err_cnt`  out  NERR  saturating count of fault events.
- `cyc`  out  NCYC  count of 15→0 wraps, modulo 2^NCYC.
- `st`  out  2  state: 00 INIT, 01 TRACK, 10 FAULT.

## Operation
- Decode is combinational: `bn[W-1]=gi[W-1]`, `bn[i]=bn[i+1]^gi[i]`. `g_q` and `b_q` hold the previous sample.
- Reset (`r`=0 at an edge) clears all outputs and internal registers to 0, with `st`=INIT. Reset wins over every other event.
- INIT: at the first non-reset edge, load `g_q`/`b_q` from `gi` and set `B`=`bn`. No checks run. Go to TRACK.
- TRACK/FAULT, at each edge:
  - `B`←`bn`, `g_q`←`gi`.
  - If `gi`≠`g_q`, classify the change:
    - `bn`=`b_q`+1 mod 16: legal step, pulse `step`. If `b_q`=15, also `cyc`←`cyc`+1.
    - `bn`=0 and `b_q`≠15: resync, pulse `rsy`. No error.
    - Anything else: jump error.
  - Flag error: `tc`≠(`bn`=15).
  - Flag error: `ceo`≠(`ce`&`tc`).
  - Any error in a cycle: `err_cnt` increments by exactly 1 (even if several errors coincide), saturating at 2^NERR−1, and `st` goes to FAULT.
- FAULT is left only by reset. `B`, `step`, `rsy` and `cyc` keep operating in FAULT.
- A legal wrap and a flag error in the same cycle produce both effects: `step`=1, `cyc`+1, `err_cnt`+1.

## Timing
- `B`: latency 1 clock from `gi`.
- `step`/`rsy`: asserted in the clock after `gi` changes, for one clock.
- `err`/`err_cnt`: updated at the edge that samples the faulty input, so visible 1 clock later.
- `gi` steady for any number of clocks: no pulses and no errors, provided the flags are consistent.
- Nominal stimulus: `ce` high 1 clock in 4, so the counter advances every 4 clocks and `step` pulses every 4 clocks.
- Reset asserted mid-operation (including in FAULT) returns to INIT at that edge. The first sample after release is never checked, so a counter reset at the same time causes no error.
- `cyc` wraps from 2^NCYC−1 to 0 silently.

## Test plan
- Reset: `r`=0 for 2 clocks with arbitrary `gi` → `B`=0, `step`=`rsy`=`err`=0, `err_cnt`=0, `cyc`=0, `st`=00. One clock after release, `st`=01.
- Full count: Gray 0000,0001,0011,0010,0110,…,1000,0000, each held 4 clocks, `ce`=1 every 4th clock, `tc`=1 only on 1000, `ceo`=`ce`&`tc` → 16 `step` pulses, `B` follows 0..15,0, `cyc`=1, `err`=0.
- Illegal jump: 0001→0010 (binary 1→3) → next clock `err`=1, `err_cnt`=1, `st`=10, `step`=0. Later legal steps still pulse `step`.
- Resync: 0110 (binary 4)→0000 → `rsy`=1 for one clock, `err`=0, `cyc` unchanged.
- Flag mismatch: `gi`=1000 with `tc`=0 → `err`=1, `err_cnt`=1. Separately, `tc`=1, `ce`=0, `ceo`=1 → `err_cnt`+1.
- Saturation and recovery: 20 consecutive illegal jumps → `err_cnt`=15 and held. Then `r`=0 for one clock → all outputs 0 and `st`=00.

Source files
------------

// File: rtl/gray4_monitor.sv
`default_nettype none
// ============================================================================
// Module   : gray4_monitor
// Purpose  : Decodes a Gray counter output, checks single-step advance and the
//            tc/ceo flags, counts wraps and fault events.
// Revision : 1.0
// ============================================================================
module gray4_monitor #(
    parameter int W    = 4,
    parameter int NCYC = 8,
    parameter int NERR = 4
) (
    input  logic            clk,
    input  logic            r,
    input  logic            ce,
    input  logic [W-1:0]    gi,
    input  logic            tc,
    input  logic            ceo,
    output logic [W-1:0]    B,
    output logic            step,
    output logic            rsy,
    output logic            err,
    output logic [NERR-1:0] err_cnt,
    output logic [NCYC-1:0] cyc,
    output logic [1:0]      st
);

    localparam logic [1:0]      c_st_init  = 2'b00;
    localparam logic [1:0]      c_st_track = 2'b01;
    localparam logic [1:0]      c_st_fault = 2'b10;
    localparam logic [W-1:0]    c_one_w    = W'(1);
    localparam logic [W-1:0]    c_ones_w   = {W{1'b1}};
    localparam logic [NCYC-1:0] c_one_cyc  = NCYC'(1);
    localparam logic [NERR-1:0] c_one_err  = NERR'(1);
    localparam logic [NERR-1:0] c_max_err  = {NERR{1'b1}};

    logic [1:0]   r_state;
    logic [1:0]   w_next_state;
    logic [W-1:0] r_g_q;
    logic [W-1:0] w_bn;
    logic [W-1:0] w_b_inc;
    logic         w_active;
    logic         w_changed;
    logic         w_legal;
    logic         w_wrap;
    logic         w_resync;
    logic         w_jump_err;
    logic         w_tc_err;
    logic         w_ceo_err;
    logic         w_fault_evt;

    // Each binary bit is the XOR of all Gray bits at and above it.
    for (genvar i = 0; i < W; i++) begin : g_decode
        assign w_bn[i] = ^gi[W-1:i];
    end

    // B always holds the previous decoded sample, so it doubles as b_q.
    assign w_b_inc     = B + c_one_w;
    assign w_active    = (r_state != c_st_init);
    assign w_changed   = (gi != r_g_q);
    assign w_legal     = w_changed && (w_bn == w_b_inc);
    assign w_wrap      = w_legal && (B == c_ones_w);
    assign w_resync    = w_changed && !w_legal && (w_bn == '0) && (B != c_ones_w);
    assign w_jump_err  = w_changed && !w_legal && !w_resync;
    assign w_tc_err    = (tc != (w_bn == c_ones_w));
    assign w_ceo_err   = (ceo != (ce & tc));
    assign w_fault_evt = w_active && (w_jump_err || w_tc_err || w_ceo_err);

    always_ff @(posedge clk) begin
        if (!r) begin
            r_state <= c_st_init;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_init:  w_next_state = c_st_track;
            c_st_track: w_next_state = w_fault_evt ? c_st_fault : c_st_track;
            c_st_fault: w_next_state = c_st_fault;
            default:    w_next_state = c_st_init;
        endcase
    end

    always_comb begin
        st  = r_state;
        err = (r_state == c_st_fault);
    end

    always_ff @(posedge clk) begin
        if (!r) begin
            B       <= '0;
            r_g_q   <= '0;
            step    <= 1'b0;
            rsy     <= 1'b0;
            cyc     <= '0;
            err_cnt <= '0;
        end else begin
            B     <= w_bn;
            r_g_q <= gi;
            step  <= w_active && w_legal;
            rsy   <= w_active && w_resync;
            if (w_active && w_wrap) begin
                cyc <= cyc + c_one_cyc;
            end
            if (w_fault_evt && (err_cnt != c_max_err)) begin
                err_cnt <= err_cnt + c_one_err;
            end
        end
    end

endmodule
`default_nettype wire
